// File: rtl/tick_prescaler.sv
// Programmable tick generator driving the count-enable of a downstream 4-bit counter.
// Optional build macro TICK_PRESCALER_LIVE_DIV_EN: reload the divide ratio on every tick while running.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet, tick_cnt holds last value
// RUN   | divider counting; emits a tick each div_q+1 cycles
// DONE  | burst finished; one-cycle done pulse, then back to IDLE
module tick_prescaler #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [DIV_W-1:0]   div_val,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0]   DIV_ONE   = 1;
  localparam logic [BURST_W-1:0] CNT_ONE   = 1;
  localparam logic [BURST_W:0]   BURST_ONE = 1;
  localparam logic [BURST_W:0]   BURST_MAX = {1'b1, {BURST_W{1'b0}}};

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_q;
  logic               mode_q;
  // One bit wider than burst_len so a zero request can hold the full 2^BURST_W length.
  logic [BURST_W:0]   len_q;
  logic [BURST_W:0]   burst_cnt;

  logic               div_hit;
  logic [BURST_W:0]   burst_nxt;
  logic               last_tick;

  assign div_hit   = (div_cnt == div_q);
  assign burst_nxt = burst_cnt + BURST_ONE;
  assign last_tick = mode_q && (burst_nxt == len_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      div_q     <= '0;
      mode_q    <= 1'b0;
      len_q     <= '0;
      burst_cnt <= '0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            div_q     <= div_val;
            mode_q    <= oneshot;
            len_q     <= (burst_len == '0) ? BURST_MAX : {1'b0, burst_len};
            div_cnt   <= '0;
            burst_cnt <= '0;
            tick_cnt  <= '0;
            state     <= RUN;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          // Stop takes priority over a coincident divider match.
          if (stop) begin
            div_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else if (div_hit) begin
            tick      <= 1'b1;
            div_cnt   <= '0;
            tick_cnt  <= tick_cnt + CNT_ONE;
            burst_cnt <= burst_nxt;
`ifdef TICK_PRESCALER_LIVE_DIV_EN
            div_q     <= div_val;
`endif
            if (last_tick) begin
              state <= DONE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_prescaler.sv
// Scoreboard bench for tick_prescaler: directed runs push expected tick/done events,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_tick_prescaler;

  typedef struct {
    bit is_done;
    int cyc;
    int cnt;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       oneshot;
  logic [7:0] div_val;
  logic [3:0] burst_len;
  logic       tick;
  logic       busy;
  logic       done;
  logic [3:0] tick_cnt;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  ev_t exp_q[$];

  tick_prescaler #(.DIV_W(8), .BURST_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .oneshot(oneshot),
    .div_val(div_val), .burst_len(burst_len),
    .tick(tick), .busy(busy), .done(done), .tick_cnt(tick_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(bit d, int c, int k);
    ev_t e;
    e.is_done = d;
    e.cyc     = c;
    e.cnt     = k;
    exp_q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_op(logic [7:0] dv, logic os, logic [3:0] bl);
    div_val   = dv;
    oneshot   = os;
    burst_len = bl;
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  // Monitor: every tick or done pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    if (tick === 1'b1 || done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse at cycle %0d: got tick=%0b done=%0b expected none", cyc, tick, done);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_done", int'(done), int'(e.is_done));
        check("event_kind_tick", int'(tick), int'(!e.is_done));
        check("event_cycle", cyc, e.cyc);
        check("event_tick_cnt", int'(tick_cnt), e.cnt);
      end
    end
  end

  initial begin
    int s;
    int last;
    reset = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    div_val = '0; burst_len = '0;

    // Reset state
    step(2);
    check("rst_tick", int'(tick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick_cnt", int'(tick_cnt), 0);
    reset = 1'b1;
    step(1);

    // Continuous, div 3: ticks every 4 edges
    s = cyc + 1;
    for (int k = 1; k <= 3; k++) push(0, s + 4 * k, k);
    start_op(8'd3, 1'b0, 4'd0);
    check("busy_after_start", int'(busy), 1);
    check("cnt_after_start", int'(tick_cnt), 0);
    goto(s + 12);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("cont_busy_after_stop", int'(busy), 0);
    check("cont_cnt_after_stop", int'(tick_cnt), 3);
    check("queue_empty_cont", exp_q.size(), 0);

    // Burst of 5 at div 1
    s = cyc + 1;
    for (int k = 1; k <= 5; k++) push(0, s + 2 * k, k);
    push(1, s + 11, 5);
    start_op(8'd1, 1'b1, 4'd5);
    goto(s + 12);
    check("burst5_busy_after_done", int'(busy), 0);
    check("burst5_done_single", int'(done), 0);
    check("burst5_cnt", int'(tick_cnt), 5);
    check("queue_empty_burst5", exp_q.size(), 0);

    // Divide-by-1, burst_len 0 means 16 ticks; tick_cnt wraps to 0
    s = cyc + 1;
    for (int k = 1; k <= 16; k++) push(0, s + k, k % 16);
    push(1, s + 17, 0);
    start_op(8'd0, 1'b1, 4'd0);
    goto(s + 18);
    check("burst16_busy", int'(busy), 0);
    check("burst16_cnt_wrap", int'(tick_cnt), 0);
    check("queue_empty_burst16", exp_q.size(), 0);

    // Start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1; div_val = 8'd0; oneshot = 1'b0;
    step(1);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle_busy", int'(busy), 0);
    step(4);
    check("start_stop_idle_busy_later", int'(busy), 0);

    // Stop on the edge where the divider would match
    s = cyc + 1;
    push(0, s + 3, 1);
    start_op(8'd2, 1'b0, 4'd0);
    goto(s + 5);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_match_tick", int'(tick), 0);
    check("stop_match_busy", int'(busy), 0);
    check("stop_match_cnt_held", int'(tick_cnt), 1);
    step(5);
    check("queue_empty_stop", exp_q.size(), 0);

    // Reset in the middle of a burst of 8
    s = cyc + 1;
    for (int k = 1; k <= 3; k++) push(0, s + 2 * k, k);
    start_op(8'd1, 1'b1, 4'd8);
    goto(s + 6);
    reset = 1'b0;
    step(1);
    check("midrst_tick", int'(tick), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_cnt", int'(tick_cnt), 0);
    reset = 1'b1;
    step(20);
    check("queue_empty_midrst", exp_q.size(), 0);

    // Start re-asserted while running is ignored
    s = cyc + 1;
    for (int k = 1; k <= 3; k++) push(0, s + 4 * k, k);
    start_op(8'd3, 1'b0, 4'd0);
    goto(s + 5);
    start = 1'b1; div_val = 8'd0; oneshot = 1'b1; burst_len = 4'd1;
    step(1);
    start = 1'b0; div_val = 8'd3;
    goto(s + 12);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("restart_ignored_cnt", int'(tick_cnt), 3);
    check("queue_empty_restart", exp_q.size(), 0);

    // div_val changed after the first tick
    s = cyc + 1;
    push(0, s + 4, 1);
    push(0, s + 8, 2);
`ifdef TICK_PRESCALER_LIVE_DIV_EN
    push(0, s + 10, 3);
    push(0, s + 12, 4);
    last = s + 12;
`else
    push(0, s + 12, 3);
    push(0, s + 16, 4);
    last = s + 16;
`endif
    start_op(8'd3, 1'b0, 4'd0);
    goto(s + 4);
    div_val = 8'd1;
    goto(last);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("live_div_cnt", int'(tick_cnt), 4);
    step(5);
    check("queue_empty_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_prescaler.md
Name: tick_prescaler

Overview:
- Programmable tick generator that sits directly upstream of the 4-bit up counter and drives its count-enable.
- Divides clk by a programmable ratio and emits one-cycle tick pulses.
- Runs continuously, or emits a fixed-length burst and then reports done.
- Start/stop control via a small FSM.

Parameters:
- DIV_W, 8, width of divide-ratio input and internal divider counter.
- BURST_W, 4, width of burst length and tick_cnt (matches 4-bit counter downstream).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk, low = reset.
- start  input  1  level-sampled start request.
- stop  input  1  level-sampled stop request.
- oneshot  input  1  mode at start: 1 = burst mode, 0 = continuous.
- div_val  input  DIV_W  divide value; tick period = div_val+1 clk cycles.
- burst_len  input  BURST_W  ticks per burst; 0 means 2^BURST_W.
- tick  output  1  registered one-cycle pulse, feeds downstream counter enable.
- busy  output  1  high when state != IDLE.
- done  output  1  one-cycle pulse after final burst tick.
- tick_cnt  output  BURST_W  ticks emitted since last start, wraps modulo 2^BURST_W.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-low.
- Reset (reset=0 at an edge):
  - state=IDLE; divider counter=0; all latched values=0.
  - tick=0, busy=0, done=0, tick_cnt=0.
  - Reset overrides all other inputs, including mid-burst. No tick or done is emitted on the reset edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0: latch div_q=div_val, mode_q=oneshot, len_q=burst_len (0 -> 2^BURST_W). Clear divider and tick_cnt; go to RUN.
  - start=1 and stop=1: stop wins; remain in IDLE, nothing latched.
- RUN:
  - Divider increments each cycle.
  - When divider==div_q: tick=1 on that edge, divider->0, tick_cnt increments.
  - Otherwise tick=0.
- Tick timing:
  - First tick asserts at the (div_q+1)-th edge after the start edge. Period is div_q+1.
  - div_q=0 gives tick high every cycle.
  - div_q=2^DIV_W-1 gives period 2^DIV_W.
- Stop in RUN:
  - stop=1 sampled: next state IDLE; tick forced 0 on that edge even if divider matches.
  - tick_cnt holds its value; divider clears.
- Start in RUN or DONE: ignored, no restart, latched values unchanged.
- Burst mode (mode_q=1):
  - When the tick being emitted is the len_q-th tick, next state is DONE.
  - In DONE: done=1 for exactly one cycle, tick=0, then IDLE.
  - stop in DONE is ignored; DONE always completes.
- Continuous mode (mode_q=0): remains in RUN until stop or reset; tick_cnt wraps 15->0 (default width).
- Latency: start edge to busy=1 is 1 edge (busy is registered from state).
- Glitch-freedom: all outputs are registered; no combinational paths from inputs to outputs.
- Input changes after start: div_val, oneshot and burst_len changes while busy have no effect (unless the optional feature below is compiled in).

Optional Feature:
- Macro: TICK_PRESCALER_LIVE_DIV_EN.
- Defined:
  - In RUN, div_q reloads from div_val on every edge where tick asserts.
  - The new period applies from the following tick interval.
  - Mode and burst length remain latched at start.
- Undefined: div_q is latched only at start; div_val is ignored while busy.

Test Plan:
- Reset then continuous run: reset=0 for 2 cycles; start=1 one cycle with div_val=3, oneshot=0 -> busy=1 next edge; tick pulses at edges 4, 8, 12 after start; tick_cnt=1, 2, 3.
- Burst of 5: div_val=1, burst_len=5, oneshot=1 -> 5 ticks, 2 cycles apart; done=1 exactly one cycle after 5th tick; busy=0 the cycle after; tick_cnt=5.
- Divide-by-1 and burst_len=0: div_val=0, burst_len=0, oneshot=1 -> tick high 16 consecutive cycles; tick_cnt wraps to 0; then done pulse.
- Stop priority: start and stop both high in IDLE -> stays IDLE. In RUN with div_val=2, assert stop on the edge divider would match -> no tick; IDLE next; tick_cnt held.
- Mid-burst reset and ignored start: burst_len=8, reset=0 after 3 ticks -> all outputs 0 the next edge, no done. Separately, re-assert start in RUN -> period and tick_cnt unaffected.
- Live divide (macro defined): div_val=3, continuous; change div_val to 1 after first tick -> second tick still 4 cycles later, subsequent ticks 2 cycles apart. Macro undefined -> all ticks 4 cycles apart.
